// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU operation codes and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the
// requester that was not granted last.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters using a
// three-state FSM (IDLE -> EXEC -> RESP) and round-robin arbitration.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0Valid,
    output logic              Req0Ready,
    input  logic [CTRL_W-1:0] Req0Control,
    input  logic [DATA_W-1:0] Req0A,
    input  logic [DATA_W-1:0] Req0B,
    output logic              Resp0Valid,
    input  logic              Resp0Ready,
    output logic [DATA_W-1:0] Resp0Data,
    output logic              Resp0Zero,
    input  logic              Req1Valid,
    output logic              Req1Ready,
    input  logic [CTRL_W-1:0] Req1Control,
    input  logic [DATA_W-1:0] Req1A,
    input  logic [DATA_W-1:0] Req1B,
    output logic              Resp1Valid,
    input  logic              Resp1Ready,
    output logic [DATA_W-1:0] Resp1Data,
    output logic              Resp1Zero,
    output logic [CTRL_W-1:0] ALUControl,
    output logic [DATA_W-1:0] DataIn0,
    output logic [DATA_W-1:0] DataIn1,
    input  logic [DATA_W-1:0] DataOut,
    input  logic              ZeroOut,
    output logic              Busy
);

    state_t state, state_n;

    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              zero_q;
    logic              gid_q;
    logic              last_q;
    logic [1:0]        grant;
    logic              accept;
    logic              resp_fire;

    rr_arbiter2 u_rr (
        .req   ({Req1Valid, Req0Valid}),
        .last  (last_q),
        .grant (grant)
    );

    // Grant is only a valid requester, so a ready output implies a handshake.
    assign Req0Ready = (state == ST_IDLE) && grant[0];
    assign Req1Ready = (state == ST_IDLE) && grant[1];
    assign accept    = Req0Ready || Req1Ready;

    assign Resp0Valid = (state == ST_RESP) && !gid_q;
    assign Resp1Valid = (state == ST_RESP) && gid_q;
    assign resp_fire  = (Resp0Valid && Resp0Ready) ||
                        (Resp1Valid && Resp1Ready);

    assign Resp0Data = Resp0Valid ? res_q : '0;
    assign Resp1Data = Resp1Valid ? res_q : '0;
    assign Resp0Zero = Resp0Valid && zero_q;
    assign Resp1Zero = Resp1Valid && zero_q;

    assign ALUControl = ctrl_q;
    assign DataIn0    = a_q;
    assign DataIn1    = b_q;
    assign Busy       = (state != ST_IDLE);

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_EXEC;
            ST_EXEC: state_n = ST_RESP;
            ST_RESP: if (resp_fire) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            ctrl_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
            gid_q  <= 1'b0;
            last_q <= 1'b1;
        end else begin
            state <= state_n;
            if (accept) begin
                ctrl_q <= grant[1] ? Req1Control : Req0Control;
                a_q    <= grant[1] ? Req1A : Req0A;
                b_q    <= grant[1] ? Req1B : Req0B;
                gid_q  <= grant[1];
            end
            if (state == ST_EXEC) begin
                res_q  <= DataOut;
                zero_q <= ZeroOut;
                last_q <= gid_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed + randomized bench for alu_arbiter with a behavioural ALU and
// a transaction-level arbitration model.
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid;
    logic        Req0Ready, Req1Ready;
    logic [3:0]  Req0Control, Req1Control;
    logic [31:0] Req0A, Req0B, Req1A, Req1B;
    logic        Resp0Valid, Resp1Valid;
    logic        Resp0Ready, Resp1Ready;
    logic [31:0] Resp0Data, Resp1Data;
    logic        Resp0Zero, Resp1Zero;
    logic [3:0]  ALUControl;
    logic [31:0] DataIn0, DataIn1, DataOut;
    logic        ZeroOut;
    logic        Busy;

    int n_chk  = 0;
    int n_fail = 0;
    int model_last = 1;

    always #5 Clock = ~Clock;

    alu_arbiter #(.DATA_W(32), .CTRL_W(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready),
        .Req0Control(Req0Control), .Req0A(Req0A), .Req0B(Req0B),
        .Resp0Valid(Resp0Valid), .Resp0Ready(Resp0Ready),
        .Resp0Data(Resp0Data), .Resp0Zero(Resp0Zero),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready),
        .Req1Control(Req1Control), .Req1A(Req1A), .Req1B(Req1B),
        .Resp1Valid(Resp1Valid), .Resp1Ready(Resp1Ready),
        .Resp1Data(Resp1Data), .Resp1Zero(Resp1Zero),
        .ALUControl(ALUControl), .DataIn0(DataIn0), .DataIn1(DataIn1),
        .DataOut(DataOut), .ZeroOut(ZeroOut), .Busy(Busy)
    );

    function automatic logic [31:0] alu_ref(input logic [3:0] c,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (c)
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a ^ b;
        endcase
    endfunction

    // External ALU seen by the DUT
    assign DataOut = alu_ref(ALUControl, DataIn0, DataIn1);
    assign ZeroOut = (DataOut == 32'd0);

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_rdy0"}, Req0Ready, 0);
        chk({tag, "_rdy1"}, Req1Ready, 0);
        chk({tag, "_rv0"}, Resp0Valid, 0);
        chk({tag, "_rv1"}, Resp1Valid, 0);
        chk({tag, "_rd0"}, Resp0Data, 0);
        chk({tag, "_rd1"}, Resp1Data, 0);
        chk({tag, "_rz0"}, Resp0Zero, 0);
        chk({tag, "_rz1"}, Resp1Zero, 0);
        chk({tag, "_ctl"}, ALUControl, 0);
        chk({tag, "_di0"}, DataIn0, 0);
        chk({tag, "_di1"}, DataIn1, 0);
    endtask

    task automatic do_reset(input string tag);
        Req0Valid  = 0;
        Req1Valid  = 0;
        Resp0Ready = 0;
        Resp1Ready = 0;
        Reset      = 1;
        #1;
        chk_all_zero(tag);
        tick();
        Reset = 0;
        model_last = 1;
    endtask

    // Runs one full transaction from IDLE with the current request inputs.
    task automatic do_op(input string tag, input int hold, output int obs_w);
        int w;
        logic [3:0]  c;
        logic [31:0] a, b, r;
        if (Req0Valid && Req1Valid) w = 1 - model_last;
        else w = Req1Valid ? 1 : 0;
        c = w ? Req1Control : Req0Control;
        a = w ? Req1A : Req0A;
        b = w ? Req1B : Req0B;
        r = alu_ref(c, a, b);
        #1;
        obs_w = Req1Ready ? 1 : 0;
        chk({tag, "_idle_busy"}, Busy, 0);
        chk({tag, "_rdy0"}, Req0Ready, w == 0);
        chk({tag, "_rdy1"}, Req1Ready, w == 1);
        tick();
        chk({tag, "_exec_busy"}, Busy, 1);
        chk({tag, "_exec_rdy"}, {Req1Ready, Req0Ready}, 0);
        chk({tag, "_exec_rv"}, {Resp1Valid, Resp0Valid}, 0);
        chk({tag, "_ctl"}, ALUControl, c);
        chk({tag, "_di0"}, DataIn0, a);
        chk({tag, "_di1"}, DataIn1, b);
        tick();
        for (int i = 0; i <= hold; i++) begin
            chk({tag, "_rv_own"}, w ? Resp1Valid : Resp0Valid, 1);
            chk({tag, "_rv_oth"}, w ? Resp0Valid : Resp1Valid, 0);
            chk({tag, "_data"}, w ? Resp1Data : Resp0Data, r);
            chk({tag, "_zero"}, w ? Resp1Zero : Resp0Zero, r == 0);
            chk({tag, "_data_oth"}, w ? Resp0Data : Resp1Data, 0);
            chk({tag, "_zero_oth"}, w ? Resp0Zero : Resp1Zero, 0);
            chk({tag, "_resp_rdy"}, {Req1Ready, Req0Ready}, 0);
            chk({tag, "_resp_busy"}, Busy, 1);
            chk({tag, "_resp_ctl"}, ALUControl, c);
            if (i == hold) begin
                if (w == 1) Resp1Ready = 1;
                else Resp0Ready = 1;
            end
            tick();
        end
        Resp0Ready = 0;
        Resp1Ready = 0;
        model_last = w;
        chk({tag, "_done_busy"}, Busy, 0);
        chk({tag, "_done_rv"}, {Resp1Valid, Resp0Valid}, 0);
    endtask

    initial begin
        int w;
        int order[4];
        order = '{0, 1, 0, 1};
        Reset = 1;
        Req0Valid = 0; Req1Valid = 0;
        Resp0Ready = 0; Resp1Ready = 0;
        Req0Control = 0; Req1Control = 0;
        Req0A = 0; Req0B = 0; Req1A = 0; Req1B = 0;
        repeat (2) @(posedge Clock);
        #1;
        chk_all_zero("reset");
        Reset = 0;
        tick();

        // single requester ADD 1,2
        Req0Valid = 1; Req0Control = ALU_ADD; Req0A = 1; Req0B = 2;
        do_op("add", 0, w);
        chk("add_owner", w, 0);
        Req0Valid = 0;

        // tie right after reset
        do_reset("rst2");
        Req0Valid = 1; Req0Control = ALU_SUB; Req0A = 4; Req0B = 4;
        Req1Valid = 1; Req1Control = ALU_SLT; Req1A = 1; Req1B = 4;
        do_op("tie_a", 0, w);
        chk("tie_a_owner", w, 0);
        Req0Valid = 0;
        do_op("tie_b", 0, w);
        chk("tie_b_owner", w, 1);
        Req1Valid = 0;

        // response back-pressure with the other requester waiting
        Req0Valid = 1; Req0Control = ALU_OR;
        Req0A = $urandom; Req0B = $urandom;
        Req1Valid = 1;
        do_op("hold", 5, w);
        Req0Valid = 0; Req1Valid = 0;

        // continuous contention, alternating grants
        do_reset("rst3");
        Req0Valid = 1; Req1Valid = 1;
        Req0Control = ALU_AND; Req0A = $urandom; Req0B = $urandom;
        Req1Control = ALU_ADD; Req1A = $urandom; Req1B = $urandom;
        for (int k = 0; k < 4; k++) begin
            do_op("rr", 0, w);
            chk("rr_order", w, order[k]);
            if (w == 0) begin
                Req0Control = 4'($urandom_range(0, 15));
                Req0A = $urandom; Req0B = $urandom;
            end else begin
                Req1Control = 4'($urandom_range(0, 15));
                Req1A = $urandom; Req1B = $urandom;
            end
        end
        Req0Valid = 0; Req1Valid = 0;

        // reset during EXEC discards the operation
        Req0Valid = 1; Req0Control = ALU_ADD; Req0A = 1; Req0B = 2;
        tick();
        chk("mid_exec_busy", Busy, 1);
        do_reset("mid_rst");
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_rv", {Resp1Valid, Resp0Valid}, 0);
            chk("post_rst_busy", Busy, 0);
        end
        Req0Valid = 1; Req0Control = ALU_SUB;
        Req0A = $urandom; Req0B = Req0A;
        Req1Valid = 1; Req1Control = ALU_SLT;
        Req1A = $urandom; Req1B = $urandom;
        do_op("post_rst_tie", 0, w);
        chk("post_rst_owner", w, 0);
        Req0Valid = 0; Req1Valid = 0;

        // randomized traffic
        for (int k = 0; k < 30; k++) begin
            int v;
            v = $urandom_range(1, 3);
            Req0Valid = v[0];
            Req1Valid = v[1];
            Req0Control = 4'($urandom_range(0, 15));
            Req1Control = 4'($urandom_range(0, 15));
            Req0A = $urandom; Req1A = $urandom;
            Req0B = ($urandom_range(0, 3) == 0) ? Req0A : $urandom;
            Req1B = ($urandom_range(0, 3) == 0) ? Req1A : $urandom;
            do_op("rand", $urandom_range(0, 3), w);
            Req0Valid = 0; Req1Valid = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
